// File: rtl/tile_seq_pkg.sv
// tile_seq_pkg: constants shared by the tile ramp sequencer and its input
// conditioning sub-module.
//   state_t     : sequencer FSM states (IDLE / WAIT / FAULT)
//   SYNC_STAGES : depth of every asynchronous-input synchronizer
package tile_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: one raw asynchronous switch -> synchronizer -> debounced level.
// The stable level only follows the synchronized input after it has differed
// from the current stable level for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_raw    : raw asynchronous switch input
//   o_stable : debounced, registered switch level
module sw_debounce
  import tile_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   w_sync;
  logic                   w_diff;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_sync != r_stable);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_diff) begin
        // Accept on the cycle the counter would reach DEBOUNCE_CYCLES.
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= w_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/tile_ramp_sequencer.sv
// tile_ramp_sequencer: conditions per-tile enable switches and drives the
// tile array enables. Turn-ons are staggered one tile per STAGGER_CYCLES,
// turn-offs are immediate, and a fault alarm forces all tiles off and
// latches until acknowledged.
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset
//   sw_req        : raw asynchronous per-tile enable switches
//   fault_in      : asynchronous active-high fault alarm
//   fault_clr     : synchronous single-cycle fault acknowledge
//   tile_en       : registered per-tile enables
//   busy          : a ramp is pending or in progress
//   fault_latched : registered, high while in FAULT
//   en_count      : popcount of tile_en
module tile_ramp_sequencer
  import tile_seq_pkg::*;
#(
  parameter int TILE_COUNT      = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STAGGER_CYCLES  = 2000000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [TILE_COUNT-1:0]           sw_req,
  input  logic                            fault_in,
  input  logic                            fault_clr,
  output logic [TILE_COUNT-1:0]           tile_en,
  output logic                            busy,
  output logic                            fault_latched,
  output logic [$clog2(TILE_COUNT+1)-1:0] en_count
);

  localparam int CNT_W = $clog2(TILE_COUNT + 1);
  localparam int TW    = $clog2(STAGGER_CYCLES);

  logic [TILE_COUNT-1:0]  w_target;
  logic [TILE_COUNT-1:0]  w_pend;
  logic [TILE_COUNT-1:0]  w_pick;
  logic [SYNC_STAGES-1:0] r_fault_sync;
  logic                   w_fault;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TILE_COUNT-1:0]  r_tile_en;
  logic [TILE_COUNT-1:0]  w_tile_nxt;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_nxt;
  logic                   r_fault_latched;
  logic                   w_fault_nxt;
  logic [CNT_W-1:0]       w_cnt;

  for (genvar g = 0; g < TILE_COUNT; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_debounce (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_raw    (sw_req[g]),
      .o_stable (w_target[g])
    );
  end

  // Fault alarm is synchronized but deliberately not debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_sync <= '0;
    end else begin
      r_fault_sync <= {r_fault_sync[SYNC_STAGES-2:0], fault_in};
    end
  end

  assign w_fault = r_fault_sync[SYNC_STAGES-1];

  // Tiles wanted on but not yet on; isolate the lowest-index one.
  assign w_pend = w_target & ~r_tile_en;
  assign w_pick = w_pend & (~w_pend + TILE_COUNT'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_tile_en       <= '0;
      r_timer         <= '0;
      r_fault_latched <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_tile_en       <= w_tile_nxt;
      r_timer         <= w_timer_nxt;
      r_fault_latched <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tile_nxt  = r_tile_en;
    w_timer_nxt = r_timer;
    w_fault_nxt = r_fault_latched;

    if (w_fault) begin
      // Fault overrides every other event in every state.
      w_state_nxt = ST_FAULT;
      w_tile_nxt  = '0;
      w_timer_nxt = '0;
      w_fault_nxt = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_tile_nxt = (r_tile_en & w_target) | w_pick;
          if (|w_pend) begin
            // Two cycles are spent in the IDLE->WAIT and WAIT->IDLE edges,
            // so rising edges land exactly STAGGER_CYCLES apart.
            w_state_nxt = ST_WAIT;
            w_timer_nxt = TW'(STAGGER_CYCLES - 2);
          end
        end
        ST_WAIT: begin
          w_tile_nxt = r_tile_en & w_target;
          if (r_timer == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        ST_FAULT: begin
          w_tile_nxt = '0;
          if (fault_clr) begin
            w_state_nxt = ST_IDLE;
            w_fault_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_tile_nxt  = '0;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < TILE_COUNT; i++) begin
      w_cnt = w_cnt + CNT_W'(r_tile_en[i]);
    end
  end

  assign tile_en       = r_tile_en;
  assign fault_latched = r_fault_latched;
  assign en_count      = w_cnt;
  assign busy          = (r_state == ST_WAIT) |
                         ((r_state != ST_FAULT) & (r_tile_en != w_target));

endmodule

// File: tb/tb_tile_ramp_sequencer.sv
// Directed bench for tile_ramp_sequencer with TILE_COUNT=4,
// DEBOUNCE_CYCLES=4, STAGGER_CYCLES=8. Edge numbering: an input changed
// between edges is first sampled at E0; "after Ek" is 1 ns past edge Ek.
module tb_tile_ramp_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_req;
  logic       fault_in;
  logic       fault_clr;
  logic [3:0] tile_en;
  logic       busy;
  logic       fault_latched;
  logic [2:0] en_count;

  int n_chk = 0;
  int n_err = 0;

  tile_ramp_sequencer #(
    .TILE_COUNT     (4),
    .DEBOUNCE_CYCLES(4),
    .STAGGER_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_req       (sw_req),
    .fault_in     (fault_in),
    .fault_clr    (fault_clr),
    .tile_en      (tile_en),
    .busy         (busy),
    .fault_latched(fault_latched),
    .en_count     (en_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] en, input logic [2:0] cnt,
                         input logic bsy, input logic flt);
    check({tag, ".tile_en"}, 32'(tile_en), 32'(en));
    check({tag, ".en_count"}, 32'(en_count), 32'(cnt));
    check({tag, ".busy"}, 32'(busy), 32'(bsy));
    check({tag, ".fault_latched"}, 32'(fault_latched), 32'(flt));
  endtask

  initial begin
    rst_n     = 1'b0;
    sw_req    = 4'hF;
    fault_in  = 1'b1;
    fault_clr = 1'b0;

    // 1: reset held with active-looking inputs
    for (int i = 0; i < 4; i++) begin
      run(1);
      chk_all("rst_hold", 4'h0, 3'd0, 1'b0, 1'b0);
    end
    sw_req   = 4'h0;
    fault_in = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(3);
    chk_all("post_rst", 4'h0, 3'd0, 1'b0, 1'b0);

    // 2: full ramp
    sw_req = 4'hF;
    run(5);  chk_all("ramp_E4", 4'h0, 3'd0, 1'b0, 1'b0);
    run(1);  chk_all("ramp_E5", 4'h0, 3'd0, 1'b1, 1'b0);
    run(1);  chk_all("ramp_E6", 4'h1, 3'd1, 1'b1, 1'b0);
    run(7);  check("ramp_E13", 32'(tile_en), 32'h1);
    run(1);  chk_all("ramp_E14", 4'h3, 3'd2, 1'b1, 1'b0);
    run(8);  chk_all("ramp_E22", 4'h7, 3'd3, 1'b1, 1'b0);
    run(8);  chk_all("ramp_E30", 4'hF, 3'd4, 1'b1, 1'b0);
    run(6);  check("ramp_E36.busy", 32'(busy), 32'h1);
    run(1);  chk_all("ramp_E37", 4'hF, 3'd4, 1'b0, 1'b0);

    // disable all from IDLE
    sw_req = 4'h0;
    run(6);  chk_all("off_E5", 4'hF, 3'd4, 1'b1, 1'b0);
    run(1);  chk_all("off_E6", 4'h0, 3'd0, 1'b0, 1'b0);

    // 3: short glitch on bit 1 is rejected
    sw_req = 4'h2;
    run(3);
    sw_req = 4'h0;
    for (int i = 0; i < 10; i++) begin
      run(1);
      check("glitch.tile_en", 32'(tile_en), 32'h0);
      check("glitch.busy", 32'(busy), 32'h0);
    end

    // 4: target drops while in WAIT with 0011
    sw_req = 4'hF;
    run(14); check("wdis_E13", 32'(tile_en), 32'h1);
    sw_req = 4'h0;
    run(1);  check("wdis_E14", 32'(tile_en), 32'h3);
    run(5);  chk_all("wdis_E19", 4'h3, 3'd2, 1'b1, 1'b0);
    run(1);  chk_all("wdis_E20", 4'h0, 3'd0, 1'b1, 1'b0);
    run(1);  chk_all("wdis_E21", 4'h0, 3'd0, 1'b0, 1'b0);

    // 5: fault with 0111 on
    sw_req = 4'hF;
    run(23); check("flt_pre", 32'(tile_en), 32'h7);
    fault_in = 1'b1;
    run(2);  chk_all("flt_F1", 4'h7, 3'd3, 1'b1, 1'b0);
    run(1);  chk_all("flt_F2", 4'h0, 3'd0, 1'b0, 1'b1);
    fault_clr = 1'b1;
    run(1);
    fault_clr = 1'b0;
    run(1);  chk_all("flt_clr_ignored", 4'h0, 3'd0, 1'b0, 1'b1);
    fault_in = 1'b0;
    run(2);
    fault_clr = 1'b1;
    run(1);  chk_all("flt_cleared", 4'h0, 3'd0, 1'b1, 1'b0);
    fault_clr = 1'b0;
    run(1);  chk_all("flt_rearm1", 4'h1, 3'd1, 1'b1, 1'b0);
    run(7);  check("flt_rearm8", 32'(tile_en), 32'h1);
    run(1);  chk_all("flt_rearm9", 4'h3, 3'd2, 1'b1, 1'b0);

    // 6: asynchronous reset mid-WAIT
    run(2);
    check("arst_pre", 32'(tile_en), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst_now", 4'h0, 3'd0, 1'b0, 1'b0);
    run(3);
    rst_n = 1'b1;
    run(6);  chk_all("arst_H5", 4'h0, 3'd0, 1'b1, 1'b0);
    run(1);  chk_all("arst_H6", 4'h1, 3'd1, 1'b1, 1'b0);
    run(8);  chk_all("arst_H14", 4'h3, 3'd2, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
